// File: rtl/mips_multicycle.sv
// Multicycle 32-bit MIPS core with one shared instruction/data memory port.
// Every access holds memreq until memready; illegal opcodes and memory timeouts trap to HALT.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned STALL_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        memreq,
  output logic        memwe,
  output logic [31:0] memaddr,
  output logic [31:0] memwdata,
  input  logic [31:0] memrdata,
  input  logic        memready,
  output logic [31:0] pc,
  output logic        halted,
  output logic [1:0]  trapcause,
  output logic [3:0]  dbg_state_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_IMMEX, S_IMMWB,
    S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_BLE = 6'b000111;
  localparam logic [5:0] OP_J = 6'b000010, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR = 6'b100101, FN_SLT = 6'b101010, FN_SLTU = 6'b101011;

  state_t      state_q, state_d;
  logic [31:0] pc_q, ir_q, a_q, b_q, aluout_q, mdr_q, stall_q;
  logic [31:0] rf_q [32];
  logic        memreq_q, memwe_q, halted_q;
  logic [1:0]  trap_q;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] simm, alu_r, imm_r;
  logic        funct_ok, taken, mem_state, timeout;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign simm   = {{16{ir_q[15]}}, ir_q[15:0]};

  assign mem_state = state_q inside {S_FETCH, S_MEMRD, S_MEMWR};
  assign timeout   = (STALL_LIMIT != 0) && (stall_q == STALL_LIMIT - 1);

  always_comb begin
    alu_r    = '0;
    funct_ok = 1'b1;
    case (funct)
      FN_ADD:  alu_r = a_q + b_q;
      FN_SUB:  alu_r = a_q - b_q;
      FN_AND:  alu_r = a_q & b_q;
      FN_OR:   alu_r = a_q | b_q;
      FN_SLT:  alu_r = {31'b0, $signed(a_q) < $signed(b_q)};
      FN_SLTU: alu_r = {31'b0, a_q < b_q};
      default: funct_ok = 1'b0;
    endcase
    imm_r = (opcode == OP_SLTI) ? {31'b0, $signed(a_q) < $signed(simm)} : a_q + simm;
    case (opcode)
      OP_BEQ:  taken = (a_q == b_q);
      OP_BNE:  taken = (a_q != b_q);
      OP_BLE:  taken = ($signed(a_q) <= $signed(b_q));
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (memready) state_d = S_DECODE; else if (timeout) state_d = S_HALT;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                state_d = S_EXEC;
          OP_LW, OP_SW:            state_d = S_MEMADR;
          OP_BEQ, OP_BNE, OP_BLE:  state_d = S_BRANCH;
          OP_J:                    state_d = S_JUMP;
          OP_ADDI, OP_SLTI:        state_d = S_IMMEX;
          default:                 state_d = S_HALT;
        endcase
      end
      S_EXEC:   state_d = funct_ok ? S_ALUWB : S_HALT;
      S_IMMEX:  state_d = S_IMMWB;
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (memready) state_d = S_MEMWB; else if (timeout) state_d = S_HALT;
      S_MEMWR:  if (memready) state_d = S_FETCH; else if (timeout) state_d = S_HALT;
      S_ALUWB, S_IMMWB, S_MEMWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      stall_q  <= '0;
      memreq_q <= 1'b0;
      memwe_q  <= 1'b0;
      halted_q <= 1'b0;
      trap_q   <= 2'd0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      // Outputs are registered from the next state so they stay pure Moore.
      memreq_q <= state_d inside {S_FETCH, S_MEMRD, S_MEMWR};
      memwe_q  <= (state_d == S_MEMWR);
      halted_q <= (state_d == S_HALT);
      if (state_d == S_HALT && state_q != S_HALT) trap_q <= mem_state ? 2'd2 : 2'd1;
      if (state_d != state_q) stall_q <= '0;
      else if (memreq_q && !memready) stall_q <= stall_q + 32'd1;
      case (state_q)
        S_FETCH:  if (memready) begin ir_q <= memrdata; pc_q <= pc_q + 32'd4; end
        S_DECODE: begin a_q <= rf_q[rs]; b_q <= rf_q[rt]; end
        S_EXEC:   aluout_q <= alu_r;
        S_ALUWB:  if (rd != 5'd0) rf_q[rd] <= aluout_q;
        S_IMMEX:  aluout_q <= imm_r;
        S_IMMWB:  if (rt != 5'd0) rf_q[rt] <= aluout_q;
        S_MEMADR: aluout_q <= a_q + simm;
        S_MEMRD:  if (memready) mdr_q <= memrdata;
        S_MEMWB:  if (rt != 5'd0) rf_q[rt] <= mdr_q;
        S_BRANCH: if (taken) pc_q <= pc_q + {simm[29:0], 2'b00};
        S_JUMP:   pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
        default:  ;
      endcase
    end
  end

  assign memreq      = memreq_q;
  assign memwe       = memwe_q;
  assign memaddr     = (state_q == S_FETCH) ? pc_q : aluout_q;
  assign memwdata    = b_q;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign trapcause   = trap_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: small programs run against a word memory model
// with programmable ready latency; results are observed through stored memory words.
module tb_mips_multicycle;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memreq, memwe, halted;
  logic [31:0] memaddr, memwdata, pc;
  logic [31:0] memrdata = '0;
  logic        memready = 1'b0;
  logic [1:0]  trapcause;
  logic [3:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] prog [256];
  logic [31:0] mem  [256];
  logic        load_req = 1'b0;
  int          delay = 0;
  int          wcnt = 0;
  int          wr_cycles = 0;
  int          rd8_cycles = 0;

  localparam logic [31:0] HALT_INSN = 32'hFC00_0000;

  always #5 clk = ~clk;

  mips_multicycle #(.RESET_PC(32'h0000_0000), .STALL_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .memreq(memreq), .memwe(memwe), .memaddr(memaddr),
    .memwdata(memwdata), .memrdata(memrdata), .memready(memready), .pc(pc),
    .halted(halted), .trapcause(trapcause), .dbg_state_o(dbg_state)
  );

  // Memory model: ready rises once `delay` wait cycles have elapsed in the current access.
  always @(negedge clk) begin
    if (memreq && wcnt >= delay) begin
      memready = 1'b1;
      memrdata = mem[memaddr[9:2]];
    end else begin
      memready = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (load_req) mem = prog;
    if (reset) begin
      wcnt = 0; wr_cycles = 0; rd8_cycles = 0;
    end else if (memreq) begin
      if (memwe) wr_cycles++;
      else if (memaddr == 32'h8) rd8_cycles++;
      if (memready) begin
        if (memwe) mem[memaddr[9:2]] = memwdata;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jtype(input logic [31:0] target);
    return {6'b000010, target[27:2]};
  endfunction

  task automatic clear_prog(input logic [31:0] fill);
    for (int i = 0; i < 256; i++) prog[i] = fill;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    load_req = 1'b0;
    reset = 1'b0;
  endtask

  task automatic wait_halt(input int max_cycles, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk); #1;
      if (halted) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (memreq !== 1'b0) begin errors++; $display("FAIL reset_memreq: got %b want 0", memreq); end
    checks++; if (memwe !== 1'b0) begin errors++; $display("FAIL reset_memwe: got %b want 0", memwe); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if (trapcause !== 2'd0) begin errors++; $display("FAIL reset_trap: got %0d want 0", trapcause); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc); end
    checks++; if (dbg_state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_arith();
    logic ok;
    clear_prog(32'h5A5A_5A5A);
    prog[0] = itype(6'b001000, 5'd0, 5'd1, 16'd5);
    prog[1] = itype(6'b001000, 5'd0, 5'd2, 16'hFFFD);
    prog[2] = rtype(5'd1, 5'd2, 5'd3, 6'b100000);
    prog[3] = itype(6'b101011, 5'd0, 5'd3, 16'h0080);
    prog[4] = HALT_INSN;
    delay = 0;
    do_reset();
    repeat (12) @(posedge clk);
    #1;
    checks++; if (memreq !== 1'b0) begin errors++; $display("FAIL arith_wb_cycle: memreq got %b want 0", memreq); end
    @(posedge clk); #1;
    checks++; if (memreq !== 1'b1 || memaddr !== 32'h0C) begin errors++; $display("FAIL arith_fetch4: memreq %b addr %h want 1 0000000c", memreq, memaddr); end
    checks++; if (pc !== 32'h0C) begin errors++; $display("FAIL arith_pc: got %h want 0000000c", pc); end
    wait_halt(40, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL arith_halt_timeout: halted got %b want 1", halted); end
    checks++; if (mem[32] !== 32'd2) begin errors++; $display("FAIL arith_add: got %h want 00000002", mem[32]); end
    checks++; if (pc !== 32'h14) begin errors++; $display("FAIL arith_halt_pc: got %h want 00000014", pc); end
  endtask

  task automatic test_mem_wait();
    logic ok;
    clear_prog(32'h0);
    prog[0]  = jtype(32'h40);
    prog[16] = itype(6'b001000, 5'd0, 5'd3, 16'd2);
    prog[17] = itype(6'b101011, 5'd0, 5'd3, 16'h0008);
    prog[18] = itype(6'b100011, 5'd0, 5'd4, 16'h0008);
    prog[19] = itype(6'b101011, 5'd0, 5'd4, 16'h0084);
    prog[20] = HALT_INSN;
    delay = 3;
    do_reset();
    wait_halt(200, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL memwait_halt_timeout: halted got %b want 1", halted); end
    checks++; if (mem[2] !== 32'd2) begin errors++; $display("FAIL memwait_sw: got %h want 00000002", mem[2]); end
    checks++; if (mem[33] !== 32'd2) begin errors++; $display("FAIL memwait_lw: got %h want 00000002", mem[33]); end
    checks++; if (wr_cycles !== 8) begin errors++; $display("FAIL memwait_wr_cycles: got %0d want 8", wr_cycles); end
    checks++; if (rd8_cycles !== 4) begin errors++; $display("FAIL memwait_rd_cycles: got %0d want 4", rd8_cycles); end
  endtask

  task automatic test_compare();
    logic ok;
    clear_prog(32'h5A5A_5A5A);
    prog[0]  = itype(6'b100011, 5'd0, 5'd1, 16'h0080);
    prog[1]  = itype(6'b100011, 5'd0, 5'd2, 16'h0084);
    prog[2]  = rtype(5'd1, 5'd2, 5'd3, 6'b101010);
    prog[3]  = rtype(5'd1, 5'd2, 5'd4, 6'b101011);
    prog[4]  = rtype(5'd1, 5'd2, 5'd6, 6'b100010);
    prog[5]  = rtype(5'd1, 5'd2, 5'd7, 6'b100100);
    prog[6]  = rtype(5'd1, 5'd2, 5'd8, 6'b100101);
    prog[7]  = itype(6'b000111, 5'd2, 5'd1, 16'd2);
    prog[8]  = itype(6'b001000, 5'd0, 5'd5, 16'd99);
    prog[9]  = itype(6'b001000, 5'd0, 5'd5, 16'd98);
    prog[10] = itype(6'b101011, 5'd0, 5'd3, 16'h00A0);
    prog[11] = itype(6'b101011, 5'd0, 5'd4, 16'h00A4);
    prog[12] = itype(6'b101011, 5'd0, 5'd5, 16'h00A8);
    prog[13] = itype(6'b101011, 5'd0, 5'd6, 16'h00AC);
    prog[14] = itype(6'b101011, 5'd0, 5'd7, 16'h00B0);
    prog[15] = itype(6'b101011, 5'd0, 5'd8, 16'h00B4);
    prog[16] = HALT_INSN;
    prog[32] = 32'h7FFF_FFFF;
    prog[33] = 32'h8000_0000;
    delay = 0;
    do_reset();
    wait_halt(200, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL cmp_halt_timeout: halted got %b want 1", halted); end
    checks++; if (mem[40] !== 32'd0) begin errors++; $display("FAIL cmp_slt: got %h want 00000000", mem[40]); end
    checks++; if (mem[41] !== 32'd1) begin errors++; $display("FAIL cmp_sltu: got %h want 00000001", mem[41]); end
    checks++; if (mem[42] !== 32'd0) begin errors++; $display("FAIL cmp_ble_taken: got %h want 00000000", mem[42]); end
    checks++; if (mem[43] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cmp_sub_wrap: got %h want ffffffff", mem[43]); end
    checks++; if (mem[44] !== 32'd0) begin errors++; $display("FAIL cmp_and: got %h want 00000000", mem[44]); end
    checks++; if (mem[45] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cmp_or: got %h want ffffffff", mem[45]); end
    checks++; if (pc !== 32'h44) begin errors++; $display("FAIL cmp_halt_pc: got %h want 00000044", pc); end
  endtask

  task automatic test_branch_jump();
    logic ok;
    clear_prog(32'h5A5A_5A5A);
    prog[0]  = itype(6'b001000, 5'd0, 5'd1, 16'd3);
    prog[1]  = itype(6'b001000, 5'd0, 5'd2, 16'd3);
    prog[2]  = itype(6'b000100, 5'd1, 5'd2, 16'd1);
    prog[3]  = itype(6'b001000, 5'd0, 5'd9, 16'd1);
    prog[4]  = itype(6'b000101, 5'd1, 5'd2, 16'd1);
    prog[5]  = itype(6'b001000, 5'd0, 5'd10, 16'd5);
    prog[6]  = jtype(32'h40);
    prog[7]  = itype(6'b001000, 5'd0, 5'd11, 16'd1);
    prog[16] = itype(6'b001000, 5'd0, 5'd0, 16'd7);
    prog[17] = itype(6'b101011, 5'd0, 5'd0, 16'h00C0);
    prog[18] = itype(6'b101011, 5'd0, 5'd9, 16'h00C4);
    prog[19] = itype(6'b101011, 5'd0, 5'd10, 16'h00C8);
    prog[20] = itype(6'b101011, 5'd0, 5'd11, 16'h00CC);
    prog[21] = itype(6'b001010, 5'd2, 5'd12, 16'd4);
    prog[22] = itype(6'b101011, 5'd0, 5'd12, 16'h00D0);
    prog[23] = HALT_INSN;
    delay = 0;
    do_reset();
    wait_halt(200, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL br_halt_timeout: halted got %b want 1", halted); end
    checks++; if (mem[48] !== 32'd0) begin errors++; $display("FAIL br_r0_write: got %h want 00000000", mem[48]); end
    checks++; if (mem[49] !== 32'd0) begin errors++; $display("FAIL br_beq_taken: got %h want 00000000", mem[49]); end
    checks++; if (mem[50] !== 32'd5) begin errors++; $display("FAIL br_bne_not_taken: got %h want 00000005", mem[50]); end
    checks++; if (mem[51] !== 32'd0) begin errors++; $display("FAIL br_jump_skip: got %h want 00000000", mem[51]); end
    checks++; if (mem[52] !== 32'd1) begin errors++; $display("FAIL br_slti: got %h want 00000001", mem[52]); end
    checks++; if (pc !== 32'h60) begin errors++; $display("FAIL br_halt_pc: got %h want 00000060", pc); end
  endtask

  task automatic test_illegal();
    logic ok;
    clear_prog(32'h0);
    for (int i = 0; i < 4; i++) prog[i] = itype(6'b001000, 5'd0, 5'd1, 16'd1);
    prog[4] = HALT_INSN;
    delay = 0;
    do_reset();
    wait_halt(100, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL illop_halt_timeout: halted got %b want 1", halted); end
    checks++; if (trapcause !== 2'd1) begin errors++; $display("FAIL illop_cause: got %0d want 1", trapcause); end
    checks++; if (pc !== 32'h14) begin errors++; $display("FAIL illop_pc: got %h want 00000014", pc); end
    repeat (3) @(posedge clk); #1;
    checks++; if (memreq !== 1'b0) begin errors++; $display("FAIL illop_memreq: got %b want 0", memreq); end
    clear_prog(32'h0);
    prog[0] = rtype(5'd1, 5'd2, 5'd3, 6'b111111);
    do_reset();
    wait_halt(100, ok);
    checks++; if (ok !== 1'b1 || trapcause !== 2'd1) begin errors++; $display("FAIL illfunct_cause: halted %b cause %0d want 1 1", halted, trapcause); end
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL illfunct_pc: got %h want 00000004", pc); end
  endtask

  task automatic test_stall_timeout();
    clear_prog(32'h0);
    delay = 1000;
    do_reset();
    repeat (4) @(posedge clk); #1;
    checks++; if (memreq !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL stall_waiting: memreq %b halted %b want 1 0", memreq, halted); end
    @(posedge clk); #1;
    checks++; if (halted !== 1'b1 || trapcause !== 2'd2) begin errors++; $display("FAIL stall_trap: halted %b cause %0d want 1 2", halted, trapcause); end
    checks++; if (memreq !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL stall_abandon: memreq %b pc %h want 0 00000000", memreq, pc); end
  endtask

  task automatic test_reset_mid_access();
    logic seen;
    clear_prog(32'h0);
    prog[0]  = itype(6'b101011, 5'd0, 5'd0, 16'h0080);
    prog[32] = 32'hDEAD_BEEF;
    delay = 3;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (memreq && memwe) begin seen = 1'b1; break; end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL midrst_reach_memwr: memwe got %b want 1", memwe); end
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checks++; if (memreq !== 1'b0 || memwe !== 1'b0) begin errors++; $display("FAIL midrst_drop: memreq %b memwe %b want 0 0", memreq, memwe); end
    repeat (2) @(posedge clk); #1;
    checks++; if (mem[32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL midrst_no_write: got %h want deadbeef", mem[32]); end
    reset = 1'b0;
    checks++; if (pc !== 32'h0 || dbg_state !== 4'd0) begin errors++; $display("FAIL midrst_idle: pc %h state %0d want 00000000 0", pc, dbg_state); end
    @(posedge clk); #1;
    checks++; if (memreq !== 1'b1 || memaddr !== 32'h0) begin errors++; $display("FAIL midrst_fetch: memreq %b addr %h want 1 00000000", memreq, memaddr); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_mem_wait();
    test_compare();
    test_branch_jump();
    test_illegal();
    test_stall_timeout();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
